// File: rtl/codma_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : codma_mem_responder
// Purpose  : Word-addressed memory slave answering DMA burst reads and writes
//            of 1..8 32-bit words. Reads return after RD_LATENCY wait cycles
//            with a one-cycle data strobe. Writes commit every word of the
//            burst on a single edge and then pulse write_done. Illegal
//            requests (misaligned address, size 0 or size > 8) produce a
//            one-cycle error strobe and leave memory untouched.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MEM_DEPTH   number of 32-bit words (power of two, 16..4096)
//   RD_LATENCY  wait cycles between read accept and read data (0..15)
// Ports
//   clk_i              clock, rising edge
//   reset_i            asynchronous active-high reset
//   addr_i[31:0]       burst byte address
//   size_i[7:0]        burst length in words (legal 1..8)
//   read_valid_i       read request
//   read_ready_o       read accept (IDLE only)
//   read_data_o[255:0] burst words, word k at [32k+31:32k], 0 when not valid
//   read_data_valid_o  one-cycle read-data strobe
//   write_valid_i      write request
//   write_ready_o      write accept (IDLE only, yields to a pending read)
//   write_data_i[255:0] burst words to store
//   write_done_o       one-cycle write-complete strobe
//   error_o            one-cycle strobe for an illegal request
// Build option
//   CODMA_RESP_STALL_EN  adds LFSR-driven ready backpressure after each
//                        response (16-bit Fibonacci, taps 16,14,13,11,
//                        seed 16'hACE1).
// ============================================================================
module codma_mem_responder #(
  parameter int MEM_DEPTH  = 256,
  parameter int RD_LATENCY = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [31:0]  addr_i,
  input  logic [7:0]   size_i,
  input  logic         read_valid_i,
  output logic         read_ready_o,
  output logic [255:0] read_data_o,
  output logic         read_data_valid_o,
  input  logic         write_valid_i,
  output logic         write_ready_o,
  input  logic [255:0] write_data_i,
  output logic         write_done_o,
  output logic         error_o
);

  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_WAIT   = 3'd1,
    S_RD_DATA   = 3'd2,
    S_WR_COMMIT = 3'd3,
    S_WR_DONE   = 3'd4,
    S_ERR       = 3'd5
  } state_t;

  state_t         state_q;
  logic           ready_q;
  logic           rd_valid_q;
  logic           wr_done_q;
  logic           err_q;
  logic [255:0]   rd_data_q;
  logic [255:0]   wr_data_q;
  logic [AW-1:0]  base_q;
  logic [3:0]     size_q;
  logic [3:0]     wait_q;

`ifdef CODMA_RESP_STALL_EN
  logic [15:0]    lfsr_q;
  logic [1:0]     stall_q;
  logic           lfsr_fb;
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
`endif

  logic [31:0]    mem [MEM_DEPTH];

  logic           rd_hs;
  logic           wr_hs;
  logic           req_bad;
  logic [AW-1:0]  rd_base;
  logic [3:0]     rd_size;
  logic [255:0]   rd_words;
  logic           unused_addr;

  // A pending read always wins over a simultaneous write.
  assign rd_hs   = read_valid_i & ready_q;
  assign wr_hs   = write_valid_i & ready_q & ~read_valid_i;
  assign req_bad = (addr_i[1:0] != 2'b00) | (size_i == 8'd0) | (size_i > 8'd8);

  // Upper address bits alias onto the word index.
  assign unused_addr = ^addr_i[31:2+AW];

  assign read_ready_o      = ready_q;
  assign write_ready_o     = ready_q & ~read_valid_i;
  assign read_data_o       = rd_data_q;
  assign read_data_valid_o = rd_valid_q;
  assign write_done_o      = wr_done_q;
  assign error_o           = err_q;

  // Burst read gather. With RD_LATENCY==0 the data is sampled on the accept
  // edge itself, before addr/size are latched, so take them from the ports.
  always_comb begin
    if (state_q == S_IDLE) begin
      rd_base = addr_i[2 +: AW];
      rd_size = size_i[3:0];
    end else begin
      rd_base = base_q;
      rd_size = size_q;
    end
    rd_words = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < rd_size) begin
        rd_words[32*k +: 32] = mem[rd_base + AW'(k)];
      end
    end
  end

  // Memory is not reset. The commit is gated by reset so a write aborted
  // before its commit edge leaves no words behind.
  always_ff @(posedge clk_i) begin
    if (!reset_i && state_q == S_WR_COMMIT) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < size_q) begin
          mem[base_q + AW'(k)] <= wr_data_q[32*k +: 32];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      wr_data_q  <= '0;
      base_q     <= '0;
      size_q     <= '0;
      wait_q     <= '0;
`ifdef CODMA_RESP_STALL_EN
      lfsr_q     <= 16'hACE1;
      stall_q    <= 2'd0;
`endif
    end else begin
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      unique case (state_q)
        S_IDLE: begin
`ifdef CODMA_RESP_STALL_EN
          if (stall_q != 2'd0) begin
            stall_q <= stall_q - 2'd1;
            ready_q <= (stall_q == 2'd1);
          end
`endif
          if (rd_hs || wr_hs) begin
            base_q  <= addr_i[2 +: AW];
            size_q  <= size_i[3:0];
            ready_q <= 1'b0;
`ifdef CODMA_RESP_STALL_EN
            lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
`endif
            if (wr_hs) begin
              wr_data_q <= write_data_i;
            end
            if (req_bad) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else if (wr_hs) begin
              state_q <= S_WR_COMMIT;
            end else if (RD_LATENCY == 0) begin
              state_q    <= S_RD_DATA;
              rd_valid_q <= 1'b1;
              rd_data_q  <= rd_words;
            end else begin
              state_q <= S_RD_WAIT;
              wait_q  <= 4'(RD_LATENCY - 1);
            end
          end
        end
        S_RD_WAIT: begin
          if (wait_q == 4'd0) begin
            state_q    <= S_RD_DATA;
            rd_valid_q <= 1'b1;
            rd_data_q  <= rd_words;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        S_WR_COMMIT: begin
          state_q   <= S_WR_DONE;
          wr_done_q <= 1'b1;
        end
        S_RD_DATA, S_WR_DONE, S_ERR: begin
          state_q <= S_IDLE;
`ifdef CODMA_RESP_STALL_EN
          // lfsr_q already holds the step taken at this request's accept.
          stall_q <= lfsr_q[1:0];
          ready_q <= (lfsr_q[1:0] == 2'd0);
`else
          ready_q <= 1'b1;
`endif
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_codma_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_codma_mem_responder
// Purpose  : Self-checking bench for codma_mem_responder. A word-array model
//            of the memory predicts read bursts, strobe timing and error
//            handling for directed and random transactions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_codma_mem_responder;

  localparam int DEPTH    = 256;
  localparam int LAT      = 2;
  localparam int HS_LIMIT = 40;
  localparam int WIN      = LAT + 4;

  logic         clk;
  logic         reset_i;
  logic [31:0]  addr_i;
  logic [7:0]   size_i;
  logic         read_valid_i;
  logic         read_ready_o;
  logic [255:0] read_data_o;
  logic         read_data_valid_o;
  logic         write_valid_i;
  logic         write_ready_o;
  logic [255:0] write_data_i;
  logic         write_done_o;
  logic         error_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [DEPTH];

  codma_mem_responder #(
    .MEM_DEPTH (DEPTH),
    .RD_LATENCY(LAT)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .addr_i           (addr_i),
    .size_i           (size_i),
    .read_valid_i     (read_valid_i),
    .read_ready_o     (read_ready_o),
    .read_data_o      (read_data_o),
    .read_data_valid_o(read_data_valid_o),
    .write_valid_i    (write_valid_i),
    .write_ready_o    (write_ready_o),
    .write_data_i     (write_data_i),
    .write_done_o     (write_done_o),
    .error_o          (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  function automatic bit ref_legal(input logic [31:0] a, input logic [7:0] s);
    return (a % 4 == 0) && (s >= 1) && (s <= 8);
  endfunction

  function automatic logic [255:0] ref_read(input logic [31:0] a, input logic [7:0] s);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 8; k++)
      if (k < int'(s)) r[32*k +: 32] = ref_mem[((a / 4) + k) % DEPTH];
    return r;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [7:0] s, input logic [255:0] d);
    for (int k = 0; k < 8; k++)
      if (k < int'(s)) ref_mem[((a / 4) + k) % DEPTH] = d[32*k +: 32];
  endtask

  // Entered just after a negedge; returns 1 ns after the accepting edge.
  task automatic handshake(input bit is_wr, input logic [31:0] a, input logic [7:0] s,
                           input logic [255:0] d, output bit ok, output int waits);
    ok = 1'b0;
    waits = 0;
    addr_i = a;
    size_i = s;
    write_data_i = d;
    if (is_wr) write_valid_i = 1'b1;
    else       read_valid_i  = 1'b1;
    #1;
    for (int i = 0; i < HS_LIMIT; i++) begin
      if (is_wr ? write_ready_o : read_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      waits++;
    end
    if (ok) @(posedge clk);
    #1;
    read_valid_i  = 1'b0;
    write_valid_i = 1'b0;
  endtask

  // Watches n cycles after an accept; cycle 1 is the cycle after the accept edge.
  task automatic collect(input int ncyc, output logic [47:0] timing,
                         output logic [255:0] data, output bit idle_zero);
    int f_rd, c_rd, f_wr, c_wr, f_er, c_er;
    f_rd = 0; c_rd = 0; f_wr = 0; c_wr = 0; f_er = 0; c_er = 0;
    data = '0;
    idle_zero = 1'b1;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (read_data_valid_o) begin
        c_rd++;
        if (f_rd == 0) f_rd = i;
        data = read_data_o;
      end else if (read_data_o !== '0) begin
        idle_zero = 1'b0;
      end
      if (write_done_o) begin c_wr++; if (f_wr == 0) f_wr = i; end
      if (error_o)      begin c_er++; if (f_er == 0) f_er = i; end
    end
    timing = {8'(c_rd), 8'(f_rd), 8'(c_wr), 8'(f_wr), 8'(c_er), 8'(f_er)};
  endtask

  task automatic finish_txn(input string tag, input bit is_wr, input logic [31:0] a,
                            input logic [7:0] s, input logic [255:0] d);
    logic [47:0]  timing;
    logic [47:0]  exp_t;
    logic [255:0] got;
    logic [255:0] exp_d;
    bit           iz;
    exp_d = ref_read(a, s);
    collect(WIN, timing, got, iz);
    if (!ref_legal(a, s))  exp_t = {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
    else if (is_wr)        exp_t = {8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd0};
    else                   exp_t = {8'd1, 8'(LAT + 1), 8'd0, 8'd0, 8'd0, 8'd0};
    chk({tag, "_timing"}, timing, exp_t);
    chk({tag, "_idle_zero"}, iz, 1'b1);
    if (ref_legal(a, s) && !is_wr) chk({tag, "_data"}, got, exp_d);
    if (ref_legal(a, s) && is_wr) ref_write(a, s, d);
  endtask

  task automatic txn(input string tag, input bit is_wr, input logic [31:0] a,
                     input logic [7:0] s, input logic [255:0] d);
    bit ok;
    int waits;
    handshake(is_wr, a, s, d, ok, waits);
    chk({tag, "_accept"}, ok, 1'b1);
    if (ok) finish_txn(tag, is_wr, a, s, d);
  endtask

  task automatic do_reset_pulse();
    reset_i = 1'b1;
    #1;
    chk("reset_outputs",
        {read_ready_o, write_ready_o, read_data_valid_o, write_done_o, error_o, read_data_o},
        {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 256'd0});
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  initial begin
    logic [255:0] d;
    logic [255:0] got;
    logic [255:0] exp_old;
    logic [47:0]  timing;
    logic [31:0]  a;
    logic [7:0]   s;
    bit           ok;
    bit           iz;
    int           waits;
    int           f_rd;
    int           f_wrdy;

    reset_i = 1'b1;
    addr_i = '0; size_i = '0; write_data_i = '0;
    read_valid_i = 1'b0; write_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state",
        {read_ready_o, write_ready_o, read_data_valid_o, write_done_o, error_o, read_data_o},
        {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 256'd0});
    reset_i = 1'b0;

    // First accept on the first edge after reset release.
    d = rand256();
    handshake(1'b1, 32'h0000_0100, 8'd8, d, ok, waits);
    chk("first_edge_accept", {ok, 8'(waits)}, {1'b1, 8'd0});
    if (ok) finish_txn("first_wr", 1'b1, 32'h0000_0100, 8'd8, d);

    // Fill all of memory so every later read is fully defined.
    for (int i = 0; i < DEPTH / 8; i++) begin
      d = rand256();
      txn("prefill", 1'b1, (32'(i) * 32) | ({$urandom} & 32'hFFFF_F000), 8'd8, d);
    end

    // Write four words then read them back; words 4..7 must come back zero.
    d = rand256();
    d[127:0] = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    txn("wr4", 1'b1, 32'h10, 8'd4, d);
    handshake(1'b0, 32'h10, 8'd4, '0, ok, waits);
    collect(WIN, timing, got, iz);
    chk("rd4_timing", timing, {8'd1, 8'(LAT + 1), 32'd0});
    chk("rd4_data", got, {128'd0, 32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});

    // Burst wraps from index 254 through 0..5.
    d = rand256();
    txn("wrap_wr", 1'b1, 32'h3F8, 8'd8, d);
    handshake(1'b0, 32'h0, 8'd6, '0, ok, waits);
    collect(WIN, timing, got, iz);
    chk("wrap_rd_data", got, {64'd0, d[255:64]});
    txn("alias_rd", 1'b0, 32'hABCD_07F8, 8'd8, '0);

    // Illegal requests: error strobe only, memory untouched.
    txn("err_misaligned_rd", 1'b0, 32'h102, 8'd4, '0);
    txn("err_size9_rd", 1'b0, 32'h100, 8'd9, '0);
    txn("err_misaligned_wr", 1'b1, 32'h11, 8'd4, rand256());
    txn("err_size0_wr", 1'b1, 32'h10, 8'd0, rand256());
    txn("err_size255_wr", 1'b1, 32'h10, 8'd255, rand256());
    txn("err_mem_intact", 1'b0, 32'h10, 8'd8, '0);

    // Simultaneous read and write: read first, write held off until IDLE.
    a = 32'h200; s = 8'd8; d = rand256();
    exp_old = ref_read(a, s);
    addr_i = a; size_i = s; write_data_i = d;
    read_valid_i = 1'b1; write_valid_i = 1'b1;
    #1;
    chk("both_ready", {read_ready_o, write_ready_o}, 2'b10);
    @(posedge clk);
    #1 read_valid_i = 1'b0;
    f_rd = 0; f_wrdy = 0; got = '0;
    for (int i = 1; i <= 20 && f_wrdy == 0; i++) begin
      @(negedge clk);
      if (read_data_valid_o) begin f_rd = i; got = read_data_o; end
      if (write_ready_o) f_wrdy = i;
    end
    chk("both_rd_cycle", f_rd, LAT + 1);
    chk("both_rd_old_data", got, exp_old);
    chk("both_wr_after_rd", (f_rd != 0) && (f_wrdy > f_rd), 1'b1);
    @(posedge clk);
    #1 write_valid_i = 1'b0;
    finish_txn("both_wr", 1'b1, a, s, d);
    txn("both_rd_new", 1'b0, a, s, '0);

    // Reset while waiting for read data: no strobe, clean recovery.
    handshake(1'b0, 32'h40, 8'd8, '0, ok, waits);
    @(negedge clk);
    do_reset_pulse();
    collect(WIN, timing, got, iz);
    chk("rd_abort_no_strobe", timing, 48'd0);
    txn("rd_after_abort", 1'b0, 32'h40, 8'd8, '0);

    // Reset before the commit edge: nothing written.
    handshake(1'b1, 32'h80, 8'd8, rand256(), ok, waits);
    @(negedge clk);
    do_reset_pulse();
    collect(WIN, timing, got, iz);
    chk("wr_abort_pre_no_strobe", timing, 48'd0);
    txn("wr_abort_pre_intact", 1'b0, 32'h80, 8'd8, '0);

    // Reset after the commit edge: the whole burst is in memory.
    d = rand256();
    handshake(1'b1, 32'h80, 8'd8, d, ok, waits);
    @(negedge clk);
    @(negedge clk);
    do_reset_pulse();
    ref_write(32'h80, 8'd8, d);
    txn("wr_abort_post_written", 1'b0, 32'h80, 8'd8, '0);

    // Random mix against the model.
    for (int i = 0; i < 60; i++) begin
      bit is_wr;
      is_wr = $urandom_range(0, 1) == 1;
      a = $urandom;
      a[1:0] = 2'b00;
      s = 8'($urandom_range(1, 8));
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       a[1:0] = 2'($urandom_range(1, 3));
          1:       s = 8'd0;
          default: s = 8'($urandom_range(9, 255));
        endcase
      end
      txn(is_wr ? "rand_wr" : "rand_rd", is_wr, a, s, rand256());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/codma_mem_responder.md
CODMA_MEM_RESPONDER -- requirements
Module: codma_mem_responder

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 256, meaning the number of 32-bit memory words (power of two, 16..4096).
REQ-002 The block SHALL have parameter RD_LATENCY, default 2, meaning the wait cycles between read accept and read data (0..15).
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port reset_i, input, 1, the reset: asynchronous, active-high.
REQ-005 The block SHALL have port addr_i, input, 32, the byte address of the burst, driven by the DMA master.
REQ-006 The block SHALL have port size_i, input, 8, the burst length in 32-bit words; legal values are 1..8.
REQ-007 The block SHALL have port read_valid_i, input, 1, the read request.
REQ-008 The block SHALL have port read_ready_o, output, 1, read accept.
REQ-009 The block SHALL have port read_data_o, output, 8x32, the burst words; word k is at bits [32k+31:32k].
REQ-010 The block SHALL have port read_data_valid_o, output, 1, a one-cycle read-data strobe.
REQ-011 The block SHALL have port write_valid_i, input, 1, the write request.
REQ-012 The block SHALL have port write_ready_o, output, 1, write accept.
REQ-013 The block SHALL have port write_data_i, input, 8x32, the burst words to store.
REQ-014 The block SHALL have port write_done_o, output, 1, a one-cycle write-complete strobe.
REQ-015 The block SHALL have port error_o, output, 1, a one-cycle strobe that replaces data_valid/done on an illegal request.

Function
REQ-016 The FSM SHALL have the states IDLE, RD_WAIT, RD_DATA, WR_COMMIT, WR_DONE and ERR.
REQ-017 read_ready_o and write_ready_o SHALL be high only in IDLE; a handshake occurs when valid is high and ready is high in the same cycle.
REQ-018 When read_valid_i and write_valid_i are both high in IDLE, the block SHALL accept the read only (write_ready_o low that cycle).
REQ-019 At any handshake the block SHALL latch addr_i, size_i and, for writes, write_data_i.
REQ-020 An accepted request with addr_i[1:0]!=0, size_i==0 or size_i>8 SHALL go to ERR, pulse error_o for 1 cycle, leave memory unchanged, then return to IDLE.
REQ-021 The word index SHALL be addr_i[2+:log2(MEM_DEPTH)]; upper address bits are ignored (aliasing).
REQ-022 Burst word k SHALL access index (base+k) mod MEM_DEPTH, wrapping at the top of memory.
REQ-023 Read path: for a handshake at cycle T, the block SHALL pass through RD_WAIT for RD_LATENCY cycles, then RD_DATA.
REQ-024 In RD_DATA the block SHALL assert read_data_valid_o for exactly one cycle at T+RD_LATENCY+1; RD_LATENCY=0 skips RD_WAIT.
REQ-025 In RD_DATA, words k>=size SHALL read as 0, and read_data_o SHALL be 0 whenever read_data_valid_o is low.
REQ-026 Write path: WR_COMMIT SHALL write all size words on a single clock edge (T+1 edge).
REQ-027 WR_DONE SHALL pulse write_done_o at cycle T+2, then return to IDLE.
REQ-028 A read SHALL always observe every write whose write_done_o has already pulsed.
REQ-029 The block SHALL ignore valid inputs outside IDLE; the master holds valid until ready.
REQ-030 Memory content SHALL NOT be reset; it is undefined until written.

Reset
REQ-031 While reset_i is high, the FSM SHALL be IDLE, read_ready_o and write_ready_o SHALL be 1, and read_data_valid_o, write_done_o, error_o and read_data_o SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL abort the request without a response strobe.
REQ-033 A write aborted by reset SHALL be all-or-nothing, depending on whether the WR_COMMIT edge occurred.
REQ-034 The first handshake SHALL be possible on the first rising edge after reset_i falls.

Configuration
REQ-035 With CODMA_RESP_STALL_EN defined, the block SHALL include a 16-bit Fibonacci LFSR (taps 16,14,13,11) with seed 16'hACE1, advancing one step per accepted request.
REQ-036 With CODMA_RESP_STALL_EN defined, IDLE SHALL keep both ready outputs low for lfsr[1:0] extra cycles after returning from any state, to exercise master backpressure.
REQ-037 Without CODMA_RESP_STALL_EN, no LFSR SHALL exist and the ready outputs SHALL be high in every IDLE cycle.

Verification
REQ-038 Write addr=0x10, size=4, words 0x11111111..0x44444444, then read the same burst -> write_done_o at T+2, then read_data_valid_o at T+3 with words 0..3 matching and words 4..7 = 0.
REQ-039 With MEM_DEPTH=256, write 8 words at addr=0x3F8 -> indices 254, 255, 0..5 written; a read at addr=0x0 with size=6 returns words 2..7 of the burst.
REQ-040 Read addr=0x102 (misaligned), then separately size=9 -> error_o pulses 1 cycle after each handshake; no data_valid/done strobe; memory is unchanged.
REQ-041 read_valid_i and write_valid_i both high in IDLE -> read accepted, write_ready_o low until the read completes, then the write is accepted.
REQ-042 Assert reset_i in RD_WAIT (RD_LATENCY=4) -> no read_data_valid_o; all outputs at reset values; a new read completes normally.
REQ-043 With CODMA_RESP_STALL_EN, 100 back-to-back reads -> every response is correct; the ready-low gap matches the LFSR sequence from seed 16'hACE1.
